isqrt_seq: RTL and testbench

Parametrised, iterative integer square-root unit with valid/ready handshakes on input and output. It returns both floor(sqrt(x)) and the remainder x − root², and resolves 1 or 2 root bits per clock. It is the general-purpose successor of the fixed 32-bit sequential square root and sits behind any producer or consumer that speaks valid/ready, including the datapath blocks in this library.

---
 rtl/isqrt_pkg.sv | 27 ++
 rtl/isqrt_if.sv | 34 +++
 rtl/isqrt_step.sv | 35 +++
 rtl/isqrt_seq.sv | 102 ++++++++++
 tb/tb_isqrt_seq.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and elaboration helpers for the iterative square-root unit.
package isqrt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } isqrt_state_e;

   function automatic int isqrt_iters(
      input int w,
      input int bpc
   );
      if (bpc < 1) return 1;
      return w / (2 * bpc);
   endfunction

   function automatic bit isqrt_legal(
      input int w,
      input int bpc
   );
      return (w >= 4) && (w % 2 == 0) &&
             (bpc == 1 || bpc == 2) &&
             ((w / 2) % bpc == 0);
   endfunction

endpackage

// File: rtl/isqrt_if.sv
// Operand/result valid-ready bundle for isqrt_seq.
interface isqrt_if #(
   parameter int WIDTH = 32
);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_x;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH/2-1:0] out_root;
   logic [WIDTH/2:0]   out_rem;

   modport master (
      output in_valid,
      output in_x,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_root,
      input  out_rem
   );

   modport slave (
      input  in_valid,
      input  in_x,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_root,
      output out_rem
   );

endinterface

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: resolves root bit i_bit.
module isqrt_step #(
   parameter int WIDTH = 32,
   parameter int IW    = 4
) (
   input  logic [WIDTH-1:0]   i_rem,
   input  logic [WIDTH/2-1:0] i_root,
   input  logic [IW-1:0]      i_bit,
   output logic [WIDTH-1:0]   o_rem,
   output logic [WIDTH/2-1:0] o_root
);

   localparam int HW = WIDTH / 2;

   logic [31:0]      w_sh;
   logic [WIDTH-1:0] w_root_ext;
   logic [WIDTH-1:0] w_one;
   logic [WIDTH-1:0] w_trial;
   logic [HW-1:0]    w_mask;
   logic             w_fit;

   assign w_sh       = 32'(i_bit);
   assign w_root_ext = {{HW{1'b0}}, i_root};
   assign w_one      = {{(WIDTH-1){1'b0}}, 1'b1};
   assign w_mask     = {{(HW-1){1'b0}}, 1'b1} << i_bit;

   // root has no bits at or below b yet, so OR-ing 4^b is an add
   assign w_trial = (w_root_ext << (w_sh + 32'd1))
                  | (w_one << (w_sh << 1));

   assign w_fit  = (w_trial <= i_rem);
   assign o_rem  = w_fit ? (i_rem - w_trial) : i_rem;
   assign o_root = w_fit ? (i_root | w_mask) : i_root;

endmodule

// File: rtl/isqrt_seq.sv
// Iterative floor-sqrt with remainder, 1 or 2 root bits per clock,
// valid/ready on both sides.
module isqrt_seq
   import isqrt_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic  clk,
   input logic  reset,
   isqrt_if.slave io
);

   localparam int HW  = WIDTH / 2;
   localparam int BPC = BITS_PER_CYCLE;
   localparam int N   = isqrt_iters(WIDTH, BPC);
   localparam int IW  = (HW > 1) ? $clog2(HW) : 1;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] BUSY = ST_BUSY;
   localparam logic [1:0] DONE = ST_DONE;

   if (!isqrt_legal(WIDTH, BPC)) begin : g_bad_params
      $error("isqrt_seq: illegal WIDTH/BITS_PER_CYCLE");
   end

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [HW-1:0]    r_root;
   logic [HW-1:0]    r_out_root;
   logic [HW:0]      r_out_rem;

   logic [WIDTH-1:0] w_rem  [BPC+1];
   logic [HW-1:0]    w_root [BPC+1];
   logic [IW-1:0]    w_bit  [BPC];
   logic             w_accept;

   assign w_rem[0]  = r_rem;
   assign w_root[0] = r_root;

   // Chain resolves bits cnt*BPC+BPC-1 down to cnt*BPC this cycle
   for (genvar j = 0; j < BPC; j++) begin : g_step
      assign w_bit[j] = IW'(32'(r_cnt) * 32'(BPC)
                          + 32'(BPC - 1 - j));

      isqrt_step #(
         .WIDTH (WIDTH),
         .IW    (IW)
      ) u_step (
         .i_rem  (w_rem[j]),
         .i_root (w_root[j]),
         .i_bit  (w_bit[j]),
         .o_rem  (w_rem[j+1]),
         .o_root (w_root[j+1])
      );
   end

   assign io.in_ready  = (r_state == IDLE) && !reset;
   assign io.out_valid = (r_state == DONE);
   assign io.out_root  = r_out_root;
   assign io.out_rem   = r_out_rem;
   assign w_accept     = io.in_valid && io.in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_root     <= '0;
         r_out_root <= '0;
         r_out_rem  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_rem   <= io.in_x;
                  r_root  <= '0;
                  r_cnt   <= CW'(N - 1);
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               r_rem  <= w_rem[BPC];
               r_root <= w_root[BPC];
               r_cnt  <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_out_root <= w_root[BPC];
                  r_out_rem  <= w_rem[BPC][HW:0];
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (io.out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed and reference-checked bench for isqrt_seq in three
// configurations: 32/1, 32/2 and 8/2.
module tb_isqrt_seq;

   logic clk = 1'b0;
   logic reset;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   isqrt_if #(.WIDTH(32)) if_a ();
   isqrt_if #(.WIDTH(32)) if_b ();
   isqrt_if #(.WIDTH(8))  if_c ();

   isqrt_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_a (
      .clk   (clk),
      .reset (reset),
      .io    (if_a)
   );

   isqrt_seq #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_b (
      .clk   (clk),
      .reset (reset),
      .io    (if_b)
   );

   isqrt_seq #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_c (
      .clk   (clk),
      .reset (reset),
      .io    (if_c)
   );

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op_a(
      input  logic [31:0] x,
      output logic [15:0] rt,
      output logic [16:0] rm,
      output int          lat
   );
      int t = 0;
      if_a.in_x     = x;
      if_a.in_valid = 1'b1;
      while (!if_a.in_ready && t < 50) begin
         tick();
         t++;
      end
      tick();
      if_a.in_valid = 1'b0;
      lat = 0;
      while (!if_a.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      rt = if_a.out_root;
      rm = if_a.out_rem;
      if_a.out_ready = 1'b1;
      tick();
      if_a.out_ready = 1'b0;
   endtask

   task automatic op_b(
      input  logic [31:0] x,
      output logic [15:0] rt,
      output logic [16:0] rm,
      output int          lat
   );
      int t = 0;
      if_b.in_x     = x;
      if_b.in_valid = 1'b1;
      while (!if_b.in_ready && t < 50) begin
         tick();
         t++;
      end
      tick();
      if_b.in_valid = 1'b0;
      lat = 0;
      while (!if_b.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      rt = if_b.out_root;
      rm = if_b.out_rem;
      if_b.out_ready = 1'b1;
      tick();
      if_b.out_ready = 1'b0;
   endtask

   task automatic op_c(
      input  logic [7:0] x,
      output logic [3:0] rt,
      output logic [4:0] rm,
      output int         lat
   );
      int t = 0;
      if_c.in_x     = x;
      if_c.in_valid = 1'b1;
      while (!if_c.in_ready && t < 50) begin
         tick();
         t++;
      end
      tick();
      if_c.in_valid = 1'b0;
      lat = 0;
      while (!if_c.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      rt = if_c.out_root;
      rm = if_c.out_rem;
      if_c.out_ready = 1'b1;
      tick();
      if_c.out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] rt;
      logic [16:0] rm;
      logic [3:0]  rt8;
      logic [4:0]  rm8;
      logic [31:0] x;
      logic [63:0] r64;
      logic [63:0] m64;
      int          lat;
      int          t;
      bit          ok;

      reset = 1'b1;
      if_a.in_valid = 1'b0; if_a.in_x = '0;
      if_a.out_ready = 1'b0;
      if_b.in_valid = 1'b0; if_b.in_x = '0;
      if_b.out_ready = 1'b0;
      if_c.in_valid = 1'b0; if_c.in_x = '0;
      if_c.out_ready = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_in_ready", if_a.in_ready, 0);
      chk("rst_out_valid", if_a.out_valid, 0);
      chk("rst_root", if_a.out_root, 0);
      chk("rst_rem", if_a.out_rem, 0);
      reset = 1'b0;
      #1;
      chk("rel_in_ready", if_a.in_ready, 1);

      // W32 BPC1 directed
      op_a(32'd0, rt, rm, lat);
      chk("a0_lat", lat, 16);
      chk("a0_root", rt, 16'h0000);
      chk("a0_rem", rm, 0);
      op_a(32'd1, rt, rm, lat);
      chk("a1_lat", lat, 16);
      chk("a1_root", rt, 1);
      chk("a1_rem", rm, 0);
      op_a(32'hFFFF_FFFF, rt, rm, lat);
      chk("aff_root", rt, 16'hFFFF);
      chk("aff_rem", rm, 17'h1FFFE);
      op_a(32'd1000000, rt, rm, lat);
      chk("a1m_root", rt, 1000);
      chk("a1m_rem", rm, 0);
      op_a(32'd99, rt, rm, lat);
      chk("a99_root", rt, 9);
      chk("a99_rem", rm, 18);
      chk("a_hold_root", if_a.out_root, 9);
      chk("a_hold_rem", if_a.out_rem, 18);

      // backpressure on x=99
      if_a.in_x     = 32'd99;
      if_a.in_valid = 1'b1;
      tick();
      if_a.in_valid = 1'b0;
      t = 0;
      while (!if_a.out_valid && t < 40) begin
         tick();
         t++;
      end
      chk("bp_lat", t, 16);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            if_a.in_x     = 32'd4;
            if_a.in_valid = 1'b1;
         end
         if (i == 6) if_a.in_valid = 1'b0;
         if (if_a.in_ready !== 1'b0 ||
             if_a.out_valid !== 1'b1 ||
             if_a.out_root !== 16'd9 ||
             if_a.out_rem !== 17'd18) ok = 1'b0;
         tick();
      end
      chk("bp_stable", ok, 1);
      if_a.out_ready = 1'b1;
      tick();
      if_a.out_ready = 1'b0;
      chk("bp_rel_ready", if_a.in_ready, 1);
      chk("bp_rel_valid", if_a.out_valid, 0);
      chk("bp_rel_root", if_a.out_root, 9);
      tick();
      chk("bp_no_accept", if_a.in_ready, 1);

      // reset mid-operation
      if_a.in_x     = 32'h1234_5678;
      if_a.in_valid = 1'b1;
      tick();
      if_a.in_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", if_a.in_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rel_ready", if_a.in_ready, 1);
      chk("mid_rst_root", if_a.out_root, 0);
      ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (if_a.out_valid !== 1'b0) ok = 1'b0;
         tick();
      end
      chk("mid_no_valid", ok, 1);
      op_a(32'd144, rt, rm, lat);
      chk("a144_lat", lat, 16);
      chk("a144_root", rt, 12);
      chk("a144_rem", rm, 0);

      // W32 BPC2
      op_b(32'hFFFF_FFFF, rt, rm, lat);
      chk("bff_lat", lat, 8);
      chk("bff_root", rt, 16'hFFFF);
      chk("bff_rem", rm, 17'h1FFFE);
      op_b(32'd99, rt, rm, lat);
      chk("b99_lat", lat, 8);
      chk("b99_root", rt, 9);
      chk("b99_rem", rm, 18);
      for (int i = 0; i < 2000; i++) begin
         x = $urandom();
         op_b(x, rt, rm, lat);
         r64 = 64'(rt);
         m64 = 64'(rm);
         chk("b_rand_sum", r64 * r64 + m64, 64'(x));
         chk("b_rand_bound", m64 <= 2 * r64, 1);
      end

      // W8 BPC2 exhaustive
      op_c(8'hFF, rt8, rm8, lat);
      chk("c255_lat", lat, 2);
      chk("c255_root", rt8, 15);
      chk("c255_rem", rm8, 30);
      for (int i = 0; i < 256; i++) begin
         op_c(8'(i), rt8, rm8, lat);
         r64 = 64'(rt8);
         m64 = 64'(rm8);
         chk("c_lat", lat, 2);
         chk("c_sum", r64 * r64 + m64, 64'(i));
         chk("c_bound", m64 <= 2 * r64, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
